// File: rtl/tx_sched_pkg.sv
// Shared definitions for the ultrasonic transmit scheduler: FSM state encoding,
// offset width and small elaboration-time helpers.
package tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_BURST  = 3'd2,
        ST_DEAD   = 3'd3,
        ST_LISTEN = 3'd4,
        ST_DONE   = 3'd5
    } sched_state_t;

    localparam int PERIOD_DEFAULT = 2500;

    // Width of a phase offset for a given PWM period (at least one bit).
    function automatic int offset_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

    localparam int OFFSET_W = offset_width(PERIOD_DEFAULT);

    // Larger of two elaboration-time integers.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_offset_gen.sv
// Running phase accumulator: acc += step, wrapped modulo PERIOD by a single
// conditional subtract. The step is assumed already clamped below PERIOD.
module phase_offset_gen #(
    parameter int PERIOD = 2500,
    parameter int W      = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] step,
    output logic [W-1:0] acc
);

    localparam logic [W:0] PERIOD_EXT = (W+1)'(PERIOD);

    logic [W-1:0] acc_r;
    logic [W:0]   sum_s;
    logic [W:0]   wrap_s;
    logic [W-1:0] acc_next_s;

    // Next accumulator value: add the step and fold back into [0, PERIOD).
    always_comb begin
        sum_s  = {1'b0, acc_r} + {1'b0, step};
        wrap_s = sum_s - PERIOD_EXT;
        if (sum_s >= PERIOD_EXT) begin
            acc_next_s = wrap_s[W-1:0];
        end else begin
            acc_next_s = sum_s[W-1:0];
        end
    end

    // Accumulator register: cleared at ping launch, stepped once per load cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {W{1'b0}};
        end else if (clear) begin
            acc_r <= {W{1'b0}};
        end else if (advance) begin
            acc_r <= acc_next_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/tx_scheduler.sv
// Ping sequencer for an ultrasonic transducer array: loads per-channel PWM
// phase offsets, gates a fixed-length burst, waits a dead time, opens an echo
// listen window and pulses done. All outputs are registered decodes of the
// next state so they line up exactly with the state occupied in each cycle.
module tx_scheduler
    import tx_sched_pkg::*;
#(
    parameter int PERIOD_IN_CLOCK_CYCLES = 2500,
    parameter int NUM_CHANNELS           = 4,
    parameter int BURST_PULSES           = 8,
    parameter int DEAD_CYCLES            = 5000,
    parameter int LISTEN_CYCLES          = 2500000
) (
    input  logic                                                clk_in,
    input  logic                                                rst_n_in,
    input  logic                                                start_in,
    input  logic                                                abort_in,
    input  logic [$clog2(PERIOD_IN_CLOCK_CYCLES)-1:0]           delay_step_in,
    input  logic                                                steer_left_in,
    output logic [NUM_CHANNELS*$clog2(PERIOD_IN_CLOCK_CYCLES)-1:0] offset_out,
    output logic                                                pwm_rst_out,
    output logic [NUM_CHANNELS-1:0]                             pwm_en_out,
    output logic                                                busy_out,
    output logic                                                listen_out,
    output logic                                                done_out
);

    localparam int OW        = $clog2(PERIOD_IN_CLOCK_CYCLES);
    localparam int BURST_LEN = BURST_PULSES * PERIOD_IN_CLOCK_CYCLES;
    localparam int MAX_LEN   = max_int(max_int(NUM_CHANNELS, BURST_LEN),
                                       max_int(DEAD_CYCLES, LISTEN_CYCLES));
    localparam int CNT_W     = $clog2(MAX_LEN + 1);
    localparam int IDX_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(NUM_CHANNELS - 1);
    localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(LISTEN_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [OW-1:0]    STEP_MAX    = OW'(PERIOD_IN_CLOCK_CYCLES - 1);
    localparam logic [OW:0]      PERIOD_EXT  = (OW+1)'(PERIOD_IN_CLOCK_CYCLES);

    sched_state_t               state_r;
    sched_state_t               next_state_s;
    logic [CNT_W-1:0]           cnt_r;
    logic                       cnt_last_s;
    logic [OW-1:0]              step_r;
    logic                       steer_r;
    logic [OW-1:0]              step_clamped_s;
    logic [OW-1:0]              acc_s;
    logic [IDX_W-1:0]           load_idx_s;
    logic                       launch_s;
    logic                       abort_s;
    logic                       timed_state_s;
    logic [NUM_CHANNELS*OW-1:0] offset_r;
    logic                       pwm_rst_r;
    logic [NUM_CHANNELS-1:0]    pwm_en_r;
    logic                       busy_r;
    logic                       listen_r;
    logic                       done_r;

    // Abort wins over start, and start is only honoured while idle.
    assign launch_s       = (state_r == ST_IDLE) && start_in && !abort_in;
    assign abort_s        = (state_r != ST_IDLE) && abort_in;
    assign step_clamped_s = ({1'b0, delay_step_in} >= PERIOD_EXT) ? STEP_MAX : delay_step_in;
    assign timed_state_s  = (state_r == ST_LOAD) || (state_r == ST_BURST) ||
                            (state_r == ST_DEAD) || (state_r == ST_LISTEN);

    // Terminal count of the shared phase counter for the current state.
    always_comb begin
        cnt_last_s = 1'b0;
        case (state_r)
            ST_LOAD:   cnt_last_s = (cnt_r == LOAD_LAST);
            ST_BURST:  cnt_last_s = (cnt_r == BURST_LAST);
            ST_DEAD:   cnt_last_s = (cnt_r == DEAD_LAST);
            ST_LISTEN: cnt_last_s = (cnt_r == LISTEN_LAST);
            default:   cnt_last_s = 1'b0;
        endcase
    end

    // Next-state logic of the ping sequence.
    always_comb begin
        next_state_s = state_r;
        if (abort_s) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   next_state_s = launch_s   ? ST_LOAD   : ST_IDLE;
                ST_LOAD:   next_state_s = cnt_last_s ? ST_BURST  : ST_LOAD;
                ST_BURST:  next_state_s = cnt_last_s ? ST_DEAD   : ST_BURST;
                ST_DEAD:   next_state_s = cnt_last_s ? ST_LISTEN : ST_DEAD;
                ST_LISTEN: next_state_s = cnt_last_s ? ST_DONE   : ST_LISTEN;
                ST_DONE:   next_state_s = ST_IDLE;
                default:   next_state_s = ST_IDLE;
            endcase
        end
    end

    // Map the load counter to the channel being written, reversed when steering left.
    always_comb begin
        if (steer_r) begin
            load_idx_s = IDX_LAST - cnt_r[IDX_W-1:0];
        end else begin
            load_idx_s = cnt_r[IDX_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Shared phase counter: restarts on every state change, counts in timed states.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != next_state_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (timed_state_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Latch step and steering direction on the launch cycle only.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            step_r  <= {OW{1'b0}};
            steer_r <= 1'b0;
        end else if (launch_s) begin
            step_r  <= step_clamped_s;
            steer_r <= steer_left_in;
        end else begin
            step_r  <= step_r;
            steer_r <= steer_r;
        end
    end

    phase_offset_gen #(
        .PERIOD (PERIOD_IN_CLOCK_CYCLES),
        .W      (OW)
    ) u_phase_offset_gen (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .clear   (launch_s),
        .advance (state_r == ST_LOAD),
        .step    (step_r),
        .acc     (acc_s)
    );

    // Offset registers: one channel written per load cycle, held otherwise (also across abort).
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            offset_r <= {(NUM_CHANNELS*OW){1'b0}};
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if ((state_r == ST_LOAD) && (load_idx_s == IDX_W'(k))) begin
                    offset_r[k*OW +: OW] <= acc_s;
                end else begin
                    offset_r[k*OW +: OW] <= offset_r[k*OW +: OW];
                end
            end
        end
    end

    // Registered status and drive outputs decoded from the state being entered.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pwm_rst_r <= 1'b1;
            pwm_en_r  <= {NUM_CHANNELS{1'b0}};
            busy_r    <= 1'b0;
            listen_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            pwm_rst_r <= (next_state_s == ST_IDLE) || (next_state_s == ST_LOAD);
            pwm_en_r  <= (next_state_s == ST_BURST) ? {NUM_CHANNELS{1'b1}} : {NUM_CHANNELS{1'b0}};
            busy_r    <= (next_state_s != ST_IDLE);
            listen_r  <= (next_state_s == ST_LISTEN);
            done_r    <= (next_state_s == ST_DONE);
        end
    end

    assign offset_out  = offset_r;
    assign pwm_rst_out = pwm_rst_r;
    assign pwm_en_out  = pwm_en_r;
    assign busy_out    = busy_r;
    assign listen_out  = listen_r;
    assign done_out    = done_r;

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler. Expected offsets are computed by a
// small reference model at launch time, queued, and compared when the burst
// starts; sequence timing is checked at the state boundaries.
module tb_tx_scheduler;

    localparam int P    = 2500;
    localparam int NCH  = 4;
    localparam int BP   = 8;
    localparam int DEAD = 5000;
    localparam int LIS  = 3000;
    localparam int OW   = $clog2(P);

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [OW-1:0]       step;
    logic                steer;
    logic [NCH*OW-1:0]   offset;
    logic                pwm_rst;
    logic [NCH-1:0]      pwm_en;
    logic                busy;
    logic                listen;
    logic                done;

    int n_vec;
    int n_err;
    int done_cnt;
    int done_ref;
    int exp_q[$];
    int last_exp[NCH];
    logic [NCH-1:0] all_en;

    tx_scheduler #(
        .PERIOD_IN_CLOCK_CYCLES (P),
        .NUM_CHANNELS           (NCH),
        .BURST_PULSES           (BP),
        .DEAD_CYCLES            (DEAD),
        .LISTEN_CYCLES          (LIS)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .start_in      (start),
        .abort_in      (abort),
        .delay_step_in (step),
        .steer_left_in (steer),
        .offset_out    (offset),
        .pwm_rst_out   (pwm_rst),
        .pwm_en_out    (pwm_en),
        .busy_out      (busy),
        .listen_out    (listen),
        .done_out      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count done pulses seen across the whole run
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // drive a one-cycle start and queue the model's expected offsets; returns at T+1
    task automatic launch(input int s, input logic left);
        int sc;
        int acc;
        int vals[NCH];
        sc  = (s >= P) ? P - 1 : s;
        acc = 0;
        for (int k = 0; k < NCH; k++) begin
            vals[k] = acc;
            acc = acc + sc;
            if (acc >= P) acc = acc - P;
        end
        for (int k = 0; k < NCH; k++) begin
            last_exp[left ? NCH - 1 - k : k] = vals[k];
        end
        for (int k = 0; k < NCH; k++) exp_q.push_back(last_exp[k]);
        step  = OW'(s);
        steer = left;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; step = '0; steer = 1'b0;
        tick(3);
        n_vec++;
        if (offset !== '0 || pwm_en !== '0 || pwm_rst !== 1'b1 || busy !== 1'b0 ||
            listen !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: off=%h en=%b rst=%b busy=%b lis=%b done=%b required off=0 en=0 rst=1 busy=0 lis=0 done=0",
                     offset, pwm_en, pwm_rst, busy, listen, done);
        end
        rst_n = 1'b1;
        tick(3);
        n_vec++;
        if (busy !== 1'b0 || pwm_rst !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_idle: busy=%b rst=%b required 0/1", busy, pwm_rst);
        end
    endtask

    task automatic test_timing();
        int got;
        int exp;
        done_ref = done_cnt;
        launch(100, 1'b0);                       // now at T+1
        n_vec++;
        if (pwm_rst !== 1'b1 || pwm_en !== '0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL load_first: rst=%b en=%b busy=%b required 1/0/1", pwm_rst, pwm_en, busy);
        end
        tick(3);                                 // T+4
        n_vec++;
        if (pwm_rst !== 1'b1 || pwm_en !== '0) begin
            n_err++;
            $display("FAIL load_last: rst=%b en=%b required 1/0", pwm_rst, pwm_en);
        end
        tick(1);                                 // T+5
        n_vec++;
        if (pwm_rst !== 1'b0 || pwm_en !== all_en) begin
            n_err++;
            $display("FAIL burst_start: rst=%b en=%b required 0/%b", pwm_rst, pwm_en, all_en);
        end
        for (int k = 0; k < NCH; k++) begin
            exp = exp_q.pop_front();
            got = int'(offset[k*OW +: OW]);
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL offset_step100_ch%0d: got %0d required %0d", k, got, exp);
            end
        end
        tick(BP * P - 1);                        // T+20004
        n_vec++;
        if (pwm_en !== all_en) begin
            n_err++;
            $display("FAIL burst_last: en=%b required %b", pwm_en, all_en);
        end
        tick(1);                                 // T+20005
        n_vec++;
        if (pwm_en !== '0 || listen !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL dead_start: en=%b lis=%b busy=%b required 0/0/1", pwm_en, listen, busy);
        end
        tick(DEAD - 1);                          // T+25004
        n_vec++;
        if (listen !== 1'b0) begin
            n_err++;
            $display("FAIL dead_last: lis=%b required 0", listen);
        end
        tick(1);                                 // T+25005
        n_vec++;
        if (listen !== 1'b1) begin
            n_err++;
            $display("FAIL listen_start: lis=%b required 1", listen);
        end
        tick(LIS - 1);
        n_vec++;
        if (listen !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL listen_last: lis=%b done=%b required 1/0", listen, done);
        end
        tick(1);
        n_vec++;
        if (done !== 1'b1 || listen !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL done_pulse: done=%b lis=%b busy=%b required 1/0/1", done, listen, busy);
        end
        tick(1);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || pwm_rst !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_idle: done=%b busy=%b rst=%b required 0/0/1", done, busy, pwm_rst);
        end
        n_vec++;
        if (done_cnt - done_ref !== 1) begin
            n_err++;
            $display("FAIL done_count: got %0d pulses required 1", done_cnt - done_ref);
        end
    endtask

    task automatic test_wrap_abort();
        int got;
        int exp;
        done_ref = done_cnt;
        launch(900, 1'b1);
        tick(4);                                 // T+5
        for (int k = 0; k < NCH; k++) begin
            exp = exp_q.pop_front();
            got = int'(offset[k*OW +: OW]);
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL offset_step900_left_ch%0d: got %0d required %0d", k, got, exp);
            end
        end
        tick(100);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || pwm_en !== '0 || listen !== 1'b0 || pwm_rst !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_burst: busy=%b en=%b lis=%b rst=%b done=%b required 0/0/0/1/0",
                     busy, pwm_en, listen, pwm_rst, done);
        end
        tick(20);
        for (int k = 0; k < NCH; k++) begin
            got = int'(offset[k*OW +: OW]);
            n_vec++;
            if (got !== last_exp[k]) begin
                n_err++;
                $display("FAIL offset_kept_ch%0d: got %0d required %0d", k, got, last_exp[k]);
            end
        end
        n_vec++;
        if (done_cnt !== done_ref || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: done pulses %0d busy=%b required 0/0", done_cnt - done_ref, busy);
        end
    endtask

    task automatic test_clamp();
        int got;
        int exp;
        int budget;
        launch(3000, 1'b0);
        budget = 0;
        while (pwm_en === '0 && budget < 20) begin
            tick(1);
            budget++;
        end
        n_vec++;
        if (pwm_en !== all_en) begin
            n_err++;
            $display("FAIL clamp_burst_wait: en=%b required %b within 20 cycles", pwm_en, all_en);
        end
        for (int k = 0; k < NCH; k++) begin
            exp = exp_q.pop_front();
            got = int'(offset[k*OW +: OW]);
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL offset_clamp_ch%0d: got %0d required %0d", k, got, exp);
            end
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(2);
    endtask

    task automatic test_start_abort();
        int got;
        done_ref = done_cnt;
        step  = OW'(50);
        steer = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || pwm_rst !== 1'b1) begin
            n_err++;
            $display("FAIL start_abort_same: busy=%b rst=%b required 0/1", busy, pwm_rst);
        end
        tick(10);
        n_vec++;
        if (busy !== 1'b0 || pwm_en !== '0 || done_cnt !== done_ref) begin
            n_err++;
            $display("FAIL start_abort_no_launch: busy=%b en=%b required 0/0", busy, pwm_en);
        end
        for (int k = 0; k < NCH; k++) begin
            got = int'(offset[k*OW +: OW]);
            n_vec++;
            if (got !== last_exp[k]) begin
                n_err++;
                $display("FAIL start_abort_offset_ch%0d: got %0d required %0d", k, got, last_exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid_listen();
        int got;
        int exp;
        done_ref = done_cnt;
        launch(100, 1'b0);
        tick(4);
        for (int k = 0; k < NCH; k++) begin
            exp = exp_q.pop_front();
            got = int'(offset[k*OW +: OW]);
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL offset_relaunch_ch%0d: got %0d required %0d", k, got, exp);
            end
        end
        tick(BP * P + DEAD + 10);                // well inside LISTEN
        start = 1'b1;
        tick(10);
        n_vec++;
        if (listen !== 1'b1 || pwm_rst !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_ignored_busy: lis=%b rst=%b busy=%b required 1/0/1", listen, pwm_rst, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (offset !== '0 || pwm_en !== '0 || pwm_rst !== 1'b1 || busy !== 1'b0 ||
            listen !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: off=%h en=%b rst=%b busy=%b lis=%b done=%b required off=0 en=0 rst=1 busy=0 lis=0 done=0",
                     offset, pwm_en, pwm_rst, busy, listen, done);
        end
        start = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        n_vec++;
        if (busy !== 1'b0 || pwm_rst !== 1'b1 || offset !== '0 || done_cnt !== done_ref) begin
            n_err++;
            $display("FAIL no_resume: busy=%b rst=%b off=%h required 0/1/0", busy, pwm_rst, offset);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        done_cnt = 0;
        done_ref = 0;
        all_en   = '1;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        step     = '0;
        steer    = 1'b0;
        test_reset();
        test_timing();
        test_wrap_abort();
        test_clamp();
        test_start_abort();
        test_reset_mid_listen();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 SHALL have parameter PERIOD_IN_CLOCK_CYCLES, default 2500, PWM period in clocks (40 kHz at 100 MHz).
REQ-002 SHALL have parameter NUM_CHANNELS, default 4, number of transducer PWM channels driven.
REQ-003 SHALL have parameter BURST_PULSES, default 8, PWM periods per transmit burst.
REQ-004 SHALL have parameter DEAD_CYCLES, default 5000, quiet clocks between burst end and listen start.
REQ-005 SHALL have parameter LISTEN_CYCLES, default 2500000, echo-listen window length in clocks.
REQ-006 SHALL have port clk_in, input, 1, sole clock; everything synchronous to its rising edge.
REQ-007 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start_in, input, 1, single-cycle request to launch one ping.
REQ-009 SHALL have port abort_in, input, 1, cancels any ping in progress.
REQ-010 SHALL have port delay_step_in, input, $clog2(PERIOD_IN_CLOCK_CYCLES), inter-channel phase step in clocks.
REQ-011 SHALL have port steer_left_in, input, 1, 0 = offsets grow with channel index, 1 = they shrink.
REQ-012 SHALL have port offset_out, output, NUM_CHANNELS x $clog2(PERIOD_IN_CLOCK_CYCLES), per-channel default_offset for the PWM instances.
REQ-013 SHALL have port pwm_rst_out, input-to-PWM reset, output, 1, holds all PWM counters in reset.
REQ-014 SHALL have port pwm_en_out, output, NUM_CHANNELS, per-channel drive gate (PWM sig ANDed externally).
REQ-015 SHALL have ports busy_out (1, high outside IDLE), listen_out (1, high in LISTEN), done_out (1, one-cycle pulse on completion).

Function
REQ-016 SHALL implement states IDLE, LOAD, BURST, DEAD, LISTEN, DONE.
REQ-017 SHALL leave IDLE for LOAD on the cycle after start_in is sampled high in IDLE; start_in outside IDLE is ignored (no queueing).
REQ-018 SHALL stay in LOAD exactly NUM_CHANNELS cycles, writing one offset per cycle, channel 0 first.
REQ-019 SHALL clamp the latched step to PERIOD_IN_CLOCK_CYCLES-1 if delay_step_in >= PERIOD_IN_CLOCK_CYCLES; delay_step_in and steer_left_in latched on the start cycle only.
REQ-020 SHALL compute offsets by running accumulator: acc starts 0, acc += step, subtract PERIOD_IN_CLOCK_CYCLES when sum >= PERIOD_IN_CLOCK_CYCLES; no multiplier or divider.
REQ-021 SHALL write acc value k into offset_out[k] when steer_left_in=0, into offset_out[NUM_CHANNELS-1-k] when 1.
REQ-022 SHALL hold offset_out stable from the last LOAD cycle until the next LOAD.
REQ-023 SHALL assert pwm_rst_out during every LOAD cycle and in IDLE, deassert in BURST/DEAD/LISTEN/DONE.
REQ-024 SHALL assert all pwm_en_out bits for exactly BURST_PULSES*PERIOD_IN_CLOCK_CYCLES cycles (BURST), zero otherwise.
REQ-025 SHALL then spend exactly DEAD_CYCLES cycles in DEAD, LISTEN_CYCLES in LISTEN, one cycle in DONE (done_out high), then IDLE.
REQ-026 SHALL on abort_in high in any non-IDLE state enter IDLE next cycle, drop pwm_en_out/listen_out, no done_out; offsets keep last written values.
REQ-027 SHALL give abort_in priority over start_in when both high in the same cycle.

Reset
REQ-028 SHALL on rst_n_in low immediately force IDLE, offset_out all 0, pwm_en_out 0, pwm_rst_out 1, busy_out/listen_out/done_out 0, counters and accumulator 0.
REQ-029 SHALL, if reset asserts mid-ping, resume only on a fresh start_in after release.

Structure
REQ-030 SHALL place state enum and width constant (OFFSET_W = $clog2(PERIOD)) in shared package tx_sched_pkg.
REQ-031 SHALL factor the accumulate-and-wrap logic into sub-module phase_offset_gen; one shared phase counter sized for the largest of the three interval lengths.

Verification
REQ-032 SHALL cover: step=100, steer_left=0 -> offset_out {0,100,200,300} for ch0..3.
REQ-033 SHALL cover: step=900, steer_left=1 -> ch3..0 = {0,900,1800,200} (wrap at 2700-2500).
REQ-034 SHALL cover: step=3000 -> clamped 2499, offsets ch0..3 {0,2499,2498,2497}.
REQ-035 SHALL cover: start at cycle T -> pwm_rst high T+1..T+4, pwm_en high T+5..T+20004, listen_out high 5000 cycles later, done_out one pulse.
REQ-036 SHALL cover: abort mid-BURST and start+abort same IDLE cycle -> IDLE next cycle, enables 0, no done_out, no launch.
REQ-037 SHALL cover: rst_n_in pulsed low mid-LISTEN -> outputs at reset values asynchronously, start_in held during busy ignored.
